// File: rtl/mips_divider_pkg.sv
// -----------------------------------------------------------------------------
// mips_div_pkg
// Shared definitions for the MIPS DIV/DIVU multi-cycle divider:
//   div_state_t       - controller states (IDLE, PREP, DIVIDE, FIX, DONE)
//   DIV_WIDTH_DEFAULT - default operand / result width
//   DIV_LATENCY       - start-to-done latency for a normal division at the
//                       default width (WIDTH + 2)
//   div_latency()     - same latency for an arbitrary width
// -----------------------------------------------------------------------------
package mips_div_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        DIVIDE = 3'd2,
        FIX    = 3'd3,
        DONE   = 3'd4
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // One PREP cycle, WIDTH DIVIDE cycles and one FIX cycle before DONE.
    function automatic int div_latency(input int width);
        return width + 2;
    endfunction

    localparam int DIV_LATENCY = DIV_WIDTH_DEFAULT + 2;

endpackage : mips_div_pkg

// File: rtl/mips_divider_if.sv
// -----------------------------------------------------------------------------
// mips_divider_if
// Request/response bundle between the register-read stage (master) and the
// divider (slave).
//   start, signed_op, dividend, divisor    : master -> divider
//   busy, done, quotient, remainder,
//   div_by_zero                            : divider -> master
// WIDTH must match the WIDTH of the divider it is connected to.
// -----------------------------------------------------------------------------
interface mips_divider_if
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) ();

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : mips_divider_if

// File: rtl/mips_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   rem_i     : current partial remainder (always < divisor_i)
//   bit_i     : next dividend bit shifted into the partial remainder
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   q_bit_o   : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Because rem_i < divisor_i, the shifted value is below 2*divisor, so the
    // true difference lies in [-divisor, divisor) and the (WIDTH+1)-bit sign
    // bit is reliable even when shifted_s itself uses its top bit.
    assign shifted_s = {rem_i, bit_i};
    assign diff_s    = shifted_s - {1'b0, divisor_i};
    assign q_bit_o   = ~diff_s[WIDTH];
    assign rem_o     = q_bit_o ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];

endmodule : div_step

// File: rtl/mips_divider.sv
// -----------------------------------------------------------------------------
// mips_divider
// Multi-cycle restoring divider implementing MIPS DIV/DIVU; one quotient bit
// per clock. Quotient is returned as LO, remainder as HI.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (returns to IDLE, clears outputs)
//   bus  : mips_divider_if.slave
//          start/signed_op/dividend/divisor sampled in IDLE or DONE;
//          busy high in PREP/DIVIDE/FIX; done pulses for one cycle in DONE;
//          quotient/remainder/div_by_zero registered and held until the
//          next result is produced.
// Configuration macro: MIPS_DIV_SIGNED_EN
//   defined   - signed_op selects DIV (two's complement) with sign fix-up
//   undefined - all operations are unsigned; PREP/FIX keep their cycles so
//               latency does not depend on the build.
// -----------------------------------------------------------------------------
module mips_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mips_divider_if.slave bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] dvd_q,     dvd_d;      // dividend, becomes the quotient
    logic [WIDTH-1:0] dvs_q,     dvs_d;      // divisor magnitude
    logic [WIDTH-1:0] prem_q,    prem_d;     // partial remainder
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q,     dbz_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [WIDTH-1:0] step_rem_s;
    logic             step_qbit_s;

`ifdef MIPS_DIV_SIGNED_EN
    logic             sgn_q,     sgn_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction
`else
    // signed_op has no effect in the unsigned-only build.
    logic unused_signed_op_s;
    assign unused_signed_op_s = bus.signed_op;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (prem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_qbit_s)
    );

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
`ifdef MIPS_DIV_SIGNED_EN
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    dvd_d = bus.dividend;
                    dvs_d = bus.divisor;
`ifdef MIPS_DIV_SIGNED_EN
                    sgn_d = bus.signed_op;
`endif
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        // Divide by zero bypasses the datapath entirely.
                        state_d   = DONE;
                        quo_out_d = {WIDTH{1'b1}};
                        rem_out_d = bus.dividend;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = PREP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            PREP: begin
`ifdef MIPS_DIV_SIGNED_EN
                dvd_d     = (sgn_q && dvd_q[WIDTH-1]) ? negate(dvd_q) : dvd_q;
                dvs_d     = (sgn_q && dvs_q[WIDTH-1]) ? negate(dvs_q) : dvs_q;
                neg_quo_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                neg_rem_d = sgn_q & dvd_q[WIDTH-1];
`else
                dvd_d     = dvd_q;
                dvs_d     = dvs_q;
`endif
                prem_d  = {WIDTH{1'b0}};
                cnt_d   = CNT_W'(WIDTH - 1);
                state_d = DIVIDE;
            end

            DIVIDE: begin
                // Quotient bits enter at the bottom as dividend bits leave
                // the top, so dvd_q holds the quotient once WIDTH steps end.
                prem_d = step_rem_s;
                dvd_d  = {dvd_q[WIDTH-2:0], step_qbit_s};
                cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    state_d = DIVIDE;
                end
            end

            FIX: begin
`ifdef MIPS_DIV_SIGNED_EN
                // The -2^(WIDTH-1) / -1 case needs no special handling: both
                // signs are negative, so the magnitude quotient is kept and
                // reads back as the wrapped value.
                quo_out_d = neg_quo_q ? negate(dvd_q) : dvd_q;
                rem_out_d = neg_rem_q ? negate(prem_q) : prem_q;
`else
                quo_out_d = dvd_q;
                rem_out_d = prem_q;
`endif
                dbz_d   = 1'b0;
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == PREP) || (state_d == DIVIDE) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            dvd_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            prem_q    <= {WIDTH{1'b0}};
            quo_out_q <= {WIDTH{1'b0}};
            rem_out_q <= {WIDTH{1'b0}};
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MIPS_DIV_SIGNED_EN
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MIPS_DIV_SIGNED_EN
            sgn_q     <= sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_out_q;
    assign bus.remainder   = rem_out_q;
    assign bus.div_by_zero = dbz_q;

endmodule : mips_divider

// File: tb/tb_mips_divider.sv
// -----------------------------------------------------------------------------
// tb_mips_divider
// Scoreboarded bench for mips_divider (WIDTH = 32). Expected results come from
// a reference model built on the simulator's own / and % operators and are
// queued when a start is driven, then popped when done is observed.
// Timing offsets are counted in rising edges after the edge that sampled
// start: a normal division shows done after edge +34, divide by zero right
// after the sampling edge (+0).
// -----------------------------------------------------------------------------
module tb_mips_divider;
    import mips_div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = DIV_LATENCY;
`ifdef MIPS_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mips_divider_if #(.WIDTH(W)) bus ();

    mips_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn);
        exp_t e;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sbv;
        logic [W-1:0] min_neg;
        min_neg = {1'b1, {(W-1){1'b0}}};
        if (b == {W{1'b0}}) begin
            e.q = {W{1'b1}}; e.r = a; e.dbz = 1'b1; e.lat = 0;
        end else begin
            e.dbz = 1'b0; e.lat = LAT;
            if (sgn && SIGNED_EN) begin
                if (a == min_neg && b == {W{1'b1}}) begin
                    e.q = min_neg; e.r = {W{1'b0}};
                end else begin
                    sa = a; sbv = b;
                    e.q = sa / sbv; e.r = sa % sbv;
                end
            end else begin
                e.q = a / b; e.r = a % b;
            end
        end
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that sampled start.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sgn);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.signed_op = sgn;
        sb.push_back(model(a, b, sgn));
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit busy_seen, output bit timed_out);
        n = 0; busy_seen = 1'b0; timed_out = 1'b0;
        while (!bus.done) begin
            if (bus.busy) busy_seen = 1'b1;
            if (n >= 200) begin timed_out = 1'b1; return; end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        vectors++; if (bus.quotient !== 32'h0) begin miscompares++; $display("FAIL reset_quotient: got %h expected 0", bus.quotient); end
        vectors++; if (bus.remainder !== 32'h0) begin miscompares++; $display("FAIL reset_remainder: got %h expected 0", bus.remainder); end
        vectors++; if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_divisions();
        logic [W-1:0] ta[9] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'h0000_1234, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'hFFFF_FFFF};
        logic [W-1:0] tb[9] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd1,
                                32'd0, 32'd0, 32'hFFFF_FFFE, 32'd9, 32'hFFFF_FFFF};
        logic         ts[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 17; i++) begin
            logic [W-1:0] a, b; logic s; int n; bit bz, to; exp_t e;
            if (i < 9) begin
                a = ta[i]; b = tb[i]; s = ts[i];
            end else begin
                a = $urandom; s = 1'(i % 2);
                b = (i % 3 == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
            end
            drive_start(a, b, s);
            wait_done(n, bz, to);
            e = sb.pop_front();
            vectors++; if (to) begin miscompares++; $display("FAIL div_timeout[%0d]: done not seen, expected within %0d edges", i, e.lat); end
            vectors++; if (n !== e.lat) begin miscompares++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, n, e.lat); end
            vectors++; if (bus.quotient !== e.q) begin miscompares++; $display("FAIL div_quotient[%0d] %h/%h s=%b: got %h expected %h", i, a, b, s, bus.quotient, e.q); end
            vectors++; if (bus.remainder !== e.r) begin miscompares++; $display("FAIL div_remainder[%0d] %h/%h s=%b: got %h expected %h", i, a, b, s, bus.remainder, e.r); end
            vectors++; if (bus.div_by_zero !== e.dbz) begin miscompares++; $display("FAIL div_dbz[%0d]: got %b expected %b", i, bus.div_by_zero, e.dbz); end
            vectors++; if (bz !== !e.dbz) begin miscompares++; $display("FAIL div_busy_seen[%0d]: got %b expected %b", i, bz, !e.dbz); end
            @(posedge clk); #1;
            vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL done_pulse[%0d]: got %b expected 0", i, bus.done); end
            vectors++; if (bus.quotient !== e.q) begin miscompares++; $display("FAIL quotient_hold[%0d]: got %h expected %h", i, bus.quotient, e.q); end
        end
        // Spot checks against hand-derived values for the first two vectors'
        // operands, independent of the model.
        drive_start(32'd100, 32'd7, 1'b0);
        begin
            int n; bit bz, to; exp_t e;
            wait_done(n, bz, to);
            e = sb.pop_front();
            vectors++; if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin miscompares++; $display("FAIL divu_100_7: got %0d r %0d expected 14 r 2", bus.quotient, bus.remainder); end
        end
        drive_start(32'hFFFF_FFF9, 32'd2, 1'b1);
        begin
            int n; bit bz, to; exp_t e;
            logic [W-1:0] eq, er;
            wait_done(n, bz, to);
            e = sb.pop_front();
            eq = SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC;
            er = SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001;
            vectors++; if (bus.quotient !== eq || bus.remainder !== er) begin miscompares++; $display("FAIL div_m7_2: got %h r %h expected %h r %h", bus.quotient, bus.remainder, eq, er); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start_and_back_to_back();
        int n; exp_t e;
        drive_start(32'd50, 32'd5, 1'b0);
        n = 0;
        while (!bus.done && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            // Edge 10 after the accepted start sees a stray request.
            if (n == 9) begin
                bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        vectors++; if (n !== LAT) begin miscompares++; $display("FAIL ignored_latency: got %0d expected %0d", n, LAT); end
        vectors++; if (bus.quotient !== e.q || bus.quotient !== 32'd10) begin miscompares++; $display("FAIL ignored_quotient: got %0d expected 10", bus.quotient); end
        vectors++; if (bus.remainder !== e.r || bus.remainder !== 32'd0) begin miscompares++; $display("FAIL ignored_remainder: got %0d expected 0", bus.remainder); end
        // Start issued in the done cycle.
        drive_start(32'd9, 32'd3, 1'b0);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_adjacent: got %b expected 1", bus.busy); end
        begin
            bit bz, to;
            wait_done(n, bz, to);
        end
        e = sb.pop_front();
        vectors++; if (n !== LAT) begin miscompares++; $display("FAIL b2b_latency: got %0d expected %0d", n, LAT); end
        vectors++; if (bus.quotient !== 32'd3 || bus.remainder !== 32'd0) begin miscompares++; $display("FAIL b2b_result: got %0d r %0d expected 3 r 0", bus.quotient, bus.remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_division();
        int n; bit bz, to; exp_t e;
        drive_start(32'd1000, 32'd7, 1'b1);
        repeat (14) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        vectors++; if (bus.quotient !== 32'h0 || bus.remainder !== 32'h0 || bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL midrst_results: got %h %h %b expected 0 0 0", bus.quotient, bus.remainder, bus.div_by_zero); end
        void'(sb.pop_back());
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        drive_start(32'd20, 32'd6, 1'b0);
        wait_done(n, bz, to);
        e = sb.pop_front();
        vectors++; if (n !== LAT) begin miscompares++; $display("FAIL post_rst_latency: got %0d expected %0d", n, LAT); end
        vectors++; if (bus.quotient !== 32'd3 || bus.remainder !== 32'd2 || bus.quotient !== e.q) begin miscompares++; $display("FAIL post_rst_result: got %0d r %0d expected 3 r 2", bus.quotient, bus.remainder); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_divisions();
        test_ignored_start_and_back_to_back();
        test_reset_mid_division();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mips_divider
